// File: rtl/ws_pkg.sv
// Shared types for the weight-stationary array sequencer:
// FSM state encoding, the result tag carried through the deskew-matching
// pipe, and the pipe latency helper.
package ws_pkg;

    // Tag index width; the sequencer's LEN_W is expected to equal this.
    localparam int WS_LEN_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } ws_seq_state_e;

    typedef struct packed {
        logic                valid;
        logic [WS_LEN_W-1:0] idx;
    } ws_tag_t;

    // Cycles from a vector entering the skew feeder to its result leaving deskew.
    function automatic int ws_lat(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/ws_tag_pipe.sv
// Fixed-latency tag shift register that tracks which deskew output cycles
// carry a real result. Never stalls; any_valid_o covers every stage.
module ws_tag_pipe
    import ws_pkg::*;
#(
    parameter int LAT = 7
) (
    input  logic    clk,
    input  logic    rst_n,
    input  ws_tag_t push_i,
    output ws_tag_t tail_o,
    output logic    any_valid_o
);

    ws_tag_t pipe_q [LAT];

    // Shift one stage per cycle; reset discards every in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= push_i;
            for (int i = 1; i < LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // OR of all stage valids, used to decide when the array has drained.
    always_comb begin
        any_valid_o = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            any_valid_o = any_valid_o | pipe_q[i].valid;
        end
    end

    assign tail_o = pipe_q[LAT-1];

endmodule

// File: rtl/ws_array_sequencer.sv
// Weight-stationary systolic array sequencer: loads one ROWS x COLS weight
// tile bottom row first, streams m_len input vectors, then waits for the
// last tagged result to leave deskew before pulsing done.
// Optional build macro WS_SEQ_PERF_EN adds perf_cycles / perf_stalls.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_W | shifting weight rows ROWS-1..0 into the cells
// STREAM | feeding vectors 0..m_len-1 into the skew feeder
// DRAIN  | waiting for the tag pipe to empty
// DONE   | one-cycle completion pulse
module ws_array_sequencer
    import ws_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int LEN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    reuse_w,
    input  logic [LEN_W-1:0]        m_len,
    input  logic                    w_valid,
    output logic                    w_rd_en,
    output logic [$clog2(ROWS)-1:0] w_rd_row,
    output logic                    store_weight_req,
    input  logic                    d_valid,
    output logic                    d_rd_en,
    output logic [LEN_W-1:0]        d_rd_idx,
    output logic                    inject,
    output logic                    out_valid,
    output logic [LEN_W-1:0]        out_idx,
    output logic                    busy,
    output logic                    done
`ifdef WS_SEQ_PERF_EN
   ,output logic [31:0]             perf_cycles,
    output logic [31:0]             perf_stalls
`endif
);

    localparam int LAT   = ws_lat(ROWS, COLS);
    localparam int ROW_W = $clog2(ROWS);

    ws_seq_state_e    state_q;
    logic [ROW_W-1:0] row_q;
    logic [LEN_W-1:0] idx_q;
    logic [LEN_W-1:0] rem_q;

    ws_tag_t push_tag;
    ws_tag_t tail_tag;
    logic    pipe_any_valid;

    // Buffer handshakes and status decoded straight from the state register.
    assign w_rd_en          = (state_q == LOAD_W);
    assign w_rd_row         = w_rd_en ? row_q : '0;
    assign store_weight_req = w_rd_en & w_valid;
    assign d_rd_en          = (state_q == STREAM);
    assign d_rd_idx         = d_rd_en ? idx_q : '0;
    assign inject           = d_rd_en & d_valid;
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);

    // Sequencer FSM; rem_q is the remaining-vector down-counter, idx_q the read index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q <= '0;
                        rem_q <= m_len;
                        row_q <= ROW_W'(ROWS - 1);
                        if (!reuse_w) begin
                            state_q <= LOAD_W;
                        end else if (m_len == '0) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= STREAM;
                        end
                    end
                end
                LOAD_W: begin
                    if (store_weight_req) begin
                        if (row_q == '0) begin
                            state_q <= (rem_q == '0) ? DONE : STREAM;
                        end else begin
                            row_q <= row_q - ROW_W'(1);
                        end
                    end
                end
                STREAM: begin
                    if (inject) begin
                        idx_q <= idx_q + LEN_W'(1);
                        rem_q <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!pipe_any_valid) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Only injected vectors carry a valid tag; bubbles push an empty slot.
    always_comb begin
        push_tag = '0;
        if (inject) begin
            push_tag.valid = 1'b1;
            push_tag.idx   = WS_LEN_W'(idx_q);
        end
    end

    ws_tag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_tag),
        .tail_o      (tail_tag),
        .any_valid_o (pipe_any_valid)
    );

    assign out_valid = tail_tag.valid;
    assign out_idx   = LEN_W'(tail_tag.idx);

`ifdef WS_SEQ_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;
    logic        start_acc;
    logic        stall_cyc;

    assign start_acc = (state_q == IDLE) & start;
    assign stall_cyc = ((state_q == LOAD_W) & ~w_valid) | ((state_q == STREAM) & ~d_valid);

    // Working cycles exclude the DONE pulse; both counters saturate.
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stalls_d = perf_stalls_q;
        if (start_acc) begin
            perf_cycles_d = '0;
            perf_stalls_d = '0;
        end else begin
            if (busy && !done && (perf_cycles_q != '1)) begin
                perf_cycles_d = perf_cycles_q + 32'd1;
            end
            if (stall_cyc && (perf_stalls_q != '1)) begin
                perf_stalls_d = perf_stalls_q + 32'd1;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_ws_array_sequencer.sv
module tb_ws_array_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        reuse_w;
    logic [15:0] m_len;
    logic        w_valid;
    logic        w_rd_en;
    logic [1:0]  w_rd_row;
    logic        store_weight_req;
    logic        d_valid;
    logic        d_rd_en;
    logic [15:0] d_rd_idx;
    logic        inject;
    logic        out_valid;
    logic [15:0] out_idx;
    logic        busy;
    logic        done;
`ifdef WS_SEQ_PERF_EN
    logic [31:0] perf_cycles;
    logic [31:0] perf_stalls;
`endif

    ws_array_sequencer #(
        .ROWS  (4),
        .COLS  (4),
        .LEN_W (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .reuse_w          (reuse_w),
        .m_len            (m_len),
        .w_valid          (w_valid),
        .w_rd_en          (w_rd_en),
        .w_rd_row         (w_rd_row),
        .store_weight_req (store_weight_req),
        .d_valid          (d_valid),
        .d_rd_en          (d_rd_en),
        .d_rd_idx         (d_rd_idx),
        .inject           (inject),
        .out_valid        (out_valid),
        .out_idx          (out_idx),
        .busy             (busy),
        .done             (done)
`ifdef WS_SEQ_PERF_EN
       ,.perf_cycles      (perf_cycles),
        .perf_stalls      (perf_stalls)
`endif
    );

    localparam int LAT = 7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    wire [40:0] all_outs = {w_rd_en, w_rd_row, store_weight_req, d_rd_en, d_rd_idx,
                            inject, out_valid, out_idx, busy, done};

    int st_k[$];
    int st_row[$];
    int inj_k[$];
    int inj_idx[$];
    int out_k[$];
    int out_i[$];
    int row_at[64];
    int wen_cnt;
    int busy_rise;
    int done_k;

    // Runs one job: start in relative cycle 0, w_valid low in cycles wlo_a/wlo_b,
    // d_valid either always high or high only in odd cycles. Start is re-asserted
    // in the done cycle to confirm it is ignored there.
    task automatic run_job(input bit reuse, input int m, input int wlo_a, input int wlo_b,
                           input bit d_toggle, input int budget);
        int k;
        bit seen_done;
        st_k.delete(); st_row.delete(); inj_k.delete(); inj_idx.delete();
        out_k.delete(); out_i.delete();
        for (int i = 0; i < 64; i++) row_at[i] = -1;
        wen_cnt = 0; busy_rise = -1; done_k = -1;
        @(posedge clk); #1;
        k = 0;
        start = 1'b1; reuse_w = reuse; m_len = 16'(m);
        w_valid = 1'b1; d_valid = !d_toggle;
        @(negedge clk);
        chk("busy_before_edge", int'(busy), 0);
        seen_done = 1'b0;
        while (!seen_done && k < budget) begin
            @(posedge clk); #1;
            k++;
            start   = 1'b0;
            w_valid = !(k == wlo_a || k == wlo_b);
            d_valid = d_toggle ? (k % 2 == 1) : 1'b1;
            @(negedge clk);
            if (busy && busy_rise < 0) busy_rise = k;
            if (w_rd_en) wen_cnt++;
            if (k < 64) row_at[k] = int'(w_rd_row);
            if (store_weight_req) begin st_k.push_back(k); st_row.push_back(int'(w_rd_row)); end
            if (inject) begin inj_k.push_back(k); inj_idx.push_back(int'(d_rd_idx)); end
            if (out_valid) begin out_k.push_back(k); out_i.push_back(int'(out_idx)); end
            if (done) begin
                seen_done = 1'b1;
                done_k    = k;
                start     = 1'b1;
            end
        end
        chk("done_seen", int'(seen_done), 1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_at_done_ignored", int'(busy), 0);
    endtask

    // Injected indices 0..n-1 at the given first cycle and step; results LAT later.
    task automatic chk_stream(input string tag, input int n, input int first_k, input int step);
        chk({tag, "_inj_cnt"}, inj_k.size(), n);
        chk({tag, "_out_cnt"}, out_k.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < inj_k.size()) begin
                chk({tag, "_inj_k"}, inj_k[i], first_k + step * i);
                chk({tag, "_inj_idx"}, inj_idx[i], i);
            end
            if (i < out_k.size()) begin
                chk({tag, "_out_k"}, out_k[i], first_k + step * i + LAT);
                chk({tag, "_out_idx"}, out_i[i], i);
            end
        end
    endtask

    task automatic chk_scn1(input string tag);
        chk({tag, "_busy_rise"}, busy_rise, 1);
        chk({tag, "_store_cnt"}, st_k.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < st_k.size()) begin
                chk({tag, "_store_k"}, st_k[i], 1 + i);
                chk({tag, "_store_row"}, st_row[i], 3 - i);
            end
        end
        chk_stream(tag, 3, 5, 1);
        chk({tag, "_latency"}, done_k - busy_rise, 15);
    endtask

    int exp_s2_k[4] = '{1, 4, 5, 6};
    int n_done;
    int n_out;
    int n_busy;

    initial begin
        rst_n = 1'b0; start = 1'b0; reuse_w = 1'b0; m_len = '0;
        w_valid = 1'b0; d_valid = 1'b0;
        #1;
        chk("reset_outs_zero", int'(all_outs != '0), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Full load, m_len=3, buffers always valid.
        run_job(1'b0, 3, -1, -1, 1'b0, 40);
        chk_scn1("s1");
`ifdef WS_SEQ_PERF_EN
        chk("s1_perf_cycles", int'(perf_cycles), 15);
        chk("s1_perf_stalls", int'(perf_stalls), 0);
`endif

        // Weight buffer stalls on the 2nd and 3rd load cycles.
        run_job(1'b0, 3, 2, 3, 1'b0, 40);
        chk("s2_wen_cycles", wen_cnt, 6);
        chk("s2_row_hold_k2", row_at[2], 2);
        chk("s2_row_hold_k3", row_at[3], 2);
        chk("s2_store_cnt", st_k.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < st_k.size()) begin
                chk("s2_store_k", st_k[i], exp_s2_k[i]);
                chk("s2_store_row", st_row[i], 3 - i);
            end
        end
        chk_stream("s2", 3, 7, 1);
        chk("s2_done_k", done_k, 18);
`ifdef WS_SEQ_PERF_EN
        chk("s2_perf_stalls", int'(perf_stalls), 2);
`endif

        // Activation bubbles: d_valid 1,0,1,0 from the first STREAM cycle.
        run_job(1'b0, 4, -1, -1, 1'b1, 40);
        chk_stream("s3", 4, 5, 2);
        chk("s3_done_k", done_k, 20);

        // Resident weights, two vectors.
        run_job(1'b1, 2, -1, -1, 1'b0, 40);
        chk("s4a_wen_cycles", wen_cnt, 0);
        chk("s4a_store_cnt", st_k.size(), 0);
        chk_stream("s4a", 2, 1, 1);
        chk("s4a_done_k", done_k, 11);

        // Resident weights, empty job.
        run_job(1'b1, 0, -1, -1, 1'b0, 20);
        chk("s4b_done_k", done_k, 1);
        chk("s4b_wen_cycles", wen_cnt, 0);
        chk("s4b_inj_cnt", inj_k.size(), 0);

        // Reset in the middle of STREAM.
        @(posedge clk); #1;
        start = 1'b1; reuse_w = 1'b0; m_len = 16'd3; w_valid = 1'b1; d_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("s5_in_stream", int'(d_rd_en), 1);
        chk("s5_inject_before_rst", int'(inject), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("s5_outs_zero_on_rst", int'(all_outs != '0), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_done = 0; n_out = 0; n_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_done += int'(done);
            n_out  += int'(out_valid);
            n_busy += int'(busy);
        end
        chk("s5_no_done_after_abort", n_done, 0);
        chk("s5_tags_discarded", n_out, 0);
        chk("s5_idle_after_abort", n_busy, 0);
        run_job(1'b0, 3, -1, -1, 1'b0, 40);
        chk_scn1("s5_rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
